// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Pipeline hazard control for a 5-stage core. Decides each cycle
//            between RUN, BUBBLE (load-use), FREEZE (cache miss) and FLUSH
//            (taken branch), drives the pipeline register enables, and keeps
//            event counters plus a sticky freeze watchdog.
// Revision : 1.0  initial release
// ============================================================================
module hazard_controller #(
  parameter int CNT_W        = 16,
  parameter int FREEZE_LIMIT = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RegSrc1_i,
  input  logic [4:0]       ID_RegSrc2_i,
  input  logic             ID_UseSrc1_i,
  input  logic             ID_UseSrc2_i,
  input  logic             ID_Branch_i,
  input  logic             ID_BranchTaken_i,
  input  logic             EX_MemRead_i,
  input  logic             EX_RegWrite_i,
  input  logic [4:0]       EX_RegDest_i,
  input  logic             MEM_MemRead_i,
  input  logic [4:0]       MEM_RegDest_i,
  input  logic             ICache_stall_i,
  input  logic             DCache_stall_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             EX_MEM_Write_o,
  output logic             MEM_WB_Write_o,
  output logic [1:0]       State_o,
  output logic [CNT_W-1:0] BubbleCnt_o,
  output logic [CNT_W-1:0] FreezeCnt_o,
  output logic             Timeout_o
);

  localparam int CONS_W = $clog2(FREEZE_LIMIT + 1);
  localparam logic [CONS_W-1:0] C_LIMIT = CONS_W'(FREEZE_LIMIT);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FREEZE = 2'd2,
    FLUSH  = 2'd3
  } action_t;

  action_t           w_action;
  action_t           r_state;
  logic [CNT_W-1:0]  r_bubbleCnt;
  logic [CNT_W-1:0]  r_freezeCnt;
  logic [CONS_W-1:0] r_consec;
  logic [CONS_W-1:0] w_consecNext;
  logic              r_timeout;
  logic              w_exMatch;
  logic              w_memMatch;
  logic              w_aluTerm;
  logic              w_hazard;
  logic              w_freeze;

  // Source-register comparison against the EX and MEM destinations; $0 never matches.
  always_comb begin
    w_exMatch  = (EX_RegDest_i != 5'd0) &&
                 ((ID_UseSrc1_i && (EX_RegDest_i == ID_RegSrc1_i)) ||
                  (ID_UseSrc2_i && (EX_RegDest_i == ID_RegSrc2_i)));
    w_memMatch = (MEM_RegDest_i != 5'd0) &&
                 ((ID_UseSrc1_i && (MEM_RegDest_i == ID_RegSrc1_i)) ||
                  (ID_UseSrc2_i && (MEM_RegDest_i == ID_RegSrc2_i)));
    // ALU producers reach the ID comparator through forwarding, so this term is
    // deliberately disabled; it is kept to document that the case was considered.
    w_aluTerm  = ID_Branch_i & EX_RegWrite_i & ~EX_MemRead_i & 1'b0;
    // A load in EX stalls any consumer; a load in MEM only stalls a branch,
    // which is what makes a load-to-branch cost two bubbles.
    w_hazard   = (EX_MemRead_i && w_exMatch) || w_aluTerm ||
                 (ID_Branch_i && MEM_MemRead_i && w_memMatch);
    w_freeze   = ICache_stall_i | DCache_stall_i;
  end

  // Action selection with FREEZE > BUBBLE > FLUSH > RUN, and the resulting enables.
  always_comb begin
    w_action       = RUN;
    PC_Write_o     = 1'b1;
    IF_ID_Write_o  = 1'b1;
    IF_ID_Flush_o  = 1'b0;
    ID_EX_Bubble_o = 1'b0;
    EX_MEM_Write_o = 1'b1;
    MEM_WB_Write_o = 1'b1;
    if (w_freeze) begin
      // Every register holds, so a pending branch is simply re-evaluated later.
      w_action       = FREEZE;
      PC_Write_o     = 1'b0;
      IF_ID_Write_o  = 1'b0;
      EX_MEM_Write_o = 1'b0;
      MEM_WB_Write_o = 1'b0;
    end else if (w_hazard) begin
      w_action       = BUBBLE;
      PC_Write_o     = 1'b0;
      IF_ID_Write_o  = 1'b0;
      ID_EX_Bubble_o = 1'b1;
    end else if (ID_BranchTaken_i) begin
      w_action      = FLUSH;
      IF_ID_Flush_o = 1'b1;
    end
  end

  // Next value of the consecutive-freeze run length, saturating at the limit.
  always_comb begin
    w_consecNext = '0;
    if (w_freeze) begin
      w_consecNext = (r_consec == C_LIMIT) ? r_consec : r_consec + 1'b1;
    end
  end

  // Action history, saturating event counters and the sticky watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_bubbleCnt <= '0;
      r_freezeCnt <= '0;
      r_consec    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state  <= w_action;
      r_consec <= w_consecNext;
      if ((w_action == BUBBLE) && (r_bubbleCnt != '1)) begin
        r_bubbleCnt <= r_bubbleCnt + 1'b1;
      end
      if ((w_action == FREEZE) && (r_freezeCnt != '1)) begin
        r_freezeCnt <= r_freezeCnt + 1'b1;
      end
      if (w_consecNext == C_LIMIT) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign State_o     = r_state;
  assign BubbleCnt_o = r_bubbleCnt;
  assign FreezeCnt_o = r_freezeCnt;
  assign Timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have these parameters: CNT_W, 16, width of the performance counters; FREEZE_LIMIT, 1023, number of consecutive freeze cycles that raises Timeout_o.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- ID_RegSrc1_i, ID_RegSrc2_i  in  5  source registers of the instruction in ID
- ID_UseSrc1_i, ID_UseSrc2_i  in  1  ID instruction actually reads that source
- ID_Branch_i  in  1  ID instruction is a branch or register jump resolved in ID
- ID_BranchTaken_i  in  1  branch outcome from the ID comparator
- EX_MemRead_i, EX_RegWrite_i  in  1  EX instruction is a load / writes a register
- EX_RegDest_i  in  5  EX destination register
- MEM_MemRead_i  in  1  MEM instruction is a load
- MEM_RegDest_i  in  5  MEM destination register
- ICache_stall_i, DCache_stall_i  in  1  cache miss in progress
- PC_Write_o  out  1  PC update enable
- IF_ID_Write_o  out  1  IF/ID register enable
- IF_ID_Flush_o  out  1  IF/ID register load of a NOP
- ID_EX_Bubble_o  out  1  ID/EX register load of a NOP
- EX_MEM_Write_o, MEM_WB_Write_o  out  1  back-end register enables
- State_o  out  2  action taken last cycle: 0 RUN, 1 BUBBLE, 2 FREEZE, 3 FLUSH
- BubbleCnt_o, FreezeCnt_o  out  CNT_W  saturating event counters
- Timeout_o  out  1  sticky freeze watchdog flag

Function
REQ-003 The block SHALL define match(d) = (d != 0) AND ((ID_UseSrc1_i AND d == ID_RegSrc1_i) OR (ID_UseSrc2_i AND d == ID_RegSrc2_i)).
REQ-004 The block SHALL define hazard = (EX_MemRead_i AND match(EX_RegDest_i)) OR (ID_Branch_i AND EX_RegWrite_i AND NOT EX_MemRead_i AND 0) OR (ID_Branch_i AND MEM_MemRead_i AND match(MEM_RegDest_i)).
- An ALU producer in EX or MEM SHALL NOT cause a hazard, because it is covered by ID forwarding.
- A load in EX feeding a branch SHALL cost 2 bubbles: the EX term fires first, then the MEM term fires.
REQ-005 The block SHALL define freeze = ICache_stall_i OR DCache_stall_i.
REQ-006 Action priority SHALL be FREEZE > BUBBLE > FLUSH > RUN, decided combinationally within the same cycle from the current inputs.
REQ-007 FREEZE SHALL drive all *_Write_o to 0 and Bubble and Flush to 0, so that every pipeline register holds.
REQ-008 BUBBLE (hazard AND NOT freeze) SHALL drive PC_Write_o=0, IF_ID_Write_o=0 and ID_EX_Bubble_o=1, with back-end enables at 1 and Flush at 0; ID_BranchTaken_i SHALL be ignored.
REQ-009 FLUSH (ID_BranchTaken_i AND NOT hazard AND NOT freeze) SHALL drive IF_ID_Flush_o=1 for exactly that cycle, with all enables at 1 and Bubble at 0.
REQ-010 RUN SHALL drive all enables to 1 and Bubble and Flush to 0.
REQ-011 State_o SHALL register the action code at each clock edge, so it shows the previous cycle's action one cycle later.
REQ-012 BubbleCnt_o SHALL increment on each BUBBLE cycle and FreezeCnt_o on each FREEZE cycle; both SHALL saturate at all-ones with no wrap.
REQ-013 An internal consecutive-freeze counter SHALL increment on each FREEZE cycle, clear on any non-FREEZE cycle, and saturate at FREEZE_LIMIT.
REQ-014 Timeout_o SHALL be set on the edge at which the consecutive-freeze count reaches FREEZE_LIMIT, and SHALL stay at 1 until reset.
REQ-015 Simultaneous freeze, hazard and taken branch SHALL yield FREEZE only; when the freeze releases, the held branch SHALL be re-evaluated.

Reset
REQ-016 When rst_i=1 at a clock edge, the block SHALL clear State_o to 0, both counters to 0, the consecutive counter to 0 and Timeout_o to 0.
REQ-017 Combinational outputs SHALL follow REQ-006..010 during reset; a reset asserted mid-freeze SHALL clear the counters regardless of the cache inputs.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- EX load with EX_RegDest=5, ID add reading $5 -> 1 cycle: PC_Write=0, IF_ID_Write=0, Bubble=1; next cycle State_o=1, BubbleCnt=1.
- EX load with dest 5 and ID beq on $5, then the load moves to MEM -> 2 consecutive BUBBLE cycles, BubbleCnt=2, then RUN/FLUSH.
- EX load with dest 0 and ID reading $0 -> RUN, no bubble.
- ID_BranchTaken=1 with no hazard -> IF_ID_Flush=1 for 1 cycle; State_o=3 on the next cycle.
- DCache_stall for 3 cycles while a load-use hazard and a taken branch are present -> 3 FREEZE cycles with all enables 0, FreezeCnt=3, then BUBBLE.
- FREEZE_LIMIT=4 with a 6-cycle ICache_stall -> Timeout_o=1 after the 4th freeze edge, still 1 after release, 0 after rst_i.
